// File: rtl/accumulator_processor.sv
// Processor side of the accumulator memory bus: fetches operand pairs, sends back their sum until memory runs dry.
// Optional feature: define ACCUM_PROC_TIMEOUT_EN to bound every wait for `signal` to TIMEOUT cycles.
`timescale 1ns/1ps

module accumulator_processor #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signal,
    input  logic [31:0]      read,
    output logic [1:0]       op,
    output logic [31:0]      write,
    output logic             done,
    output logic [31:0]      result,
    output logic [CNT_W-1:0] adds,
    output logic             ovf,
    output logic             busy,
    output logic [7:0]       state
`ifdef ACCUM_PROC_TIMEOUT_EN
    ,
    output logic             timeout_err
`endif
);

    typedef enum logic [7:0] {
        S_IDLE   = 8'b0000_0001,
        S_REQ_A  = 8'b0000_0010,
        S_WAIT_A = 8'b0000_0100,
        S_REQ_B  = 8'b0000_1000,
        S_WAIT_B = 8'b0001_0000,
        S_REQ_S  = 8'b0010_0000,
        S_WAIT_S = 8'b0100_0000,
        S_DONE   = 8'b1000_0000
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_FETCH = 2'b01,
        OP_SEND  = 2'b10
    } op_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] a;
    logic [32:0] sum;
    logic        wait_expired;

    assign sum   = {1'b0, a} + {1'b0, read};
    assign state = state_q;

`ifdef ACCUM_PROC_TIMEOUT_EN
    localparam int               WAIT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              in_wait;

    assign in_wait      = (state_q == S_WAIT_A) || (state_q == S_WAIT_B) || (state_q == S_WAIT_S);
    assign wait_expired = in_wait && (wait_cnt == WAIT_LAST);

    // Every WAIT_* state is entered from a REQ_* state, so the count restarts at zero on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt <= in_wait ? wait_cnt + WAIT_W'(1) : '0;
            if (wait_expired && !signal)
                timeout_err <= 1'b1;
        end
    end
`else
    // Waits are unbounded; TIMEOUT has no effect in this build.
    assign wait_expired = (TIMEOUT < 0);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // NOTE: next-state gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_REQ_A;
            S_REQ_A:  state_d = S_WAIT_A;
            S_WAIT_A: begin
                if (signal)
                    state_d = (read == '0) ? S_DONE : S_REQ_B;
                else if (wait_expired)
                    state_d = S_DONE;
            end
            S_REQ_B:  state_d = S_WAIT_B;
            S_WAIT_B: begin
                if (signal)
                    state_d = (read == '0) ? S_DONE : S_REQ_S;
                else if (wait_expired)
                    state_d = S_DONE;
            end
            S_REQ_S:  state_d = S_WAIT_S;
            S_WAIT_S: begin
                if (signal)
                    state_d = S_REQ_A;
                else if (wait_expired)
                    state_d = S_DONE;
            end
            S_DONE:   state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op   <= OP_NOP;
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            if ((state_d == S_REQ_A) || (state_d == S_REQ_B))
                op <= OP_FETCH;
            else if (state_d == S_REQ_S)
                op <= OP_SEND;
            else
                op <= OP_NOP;
            done <= (state_d == S_DONE);
            busy <= (state_d != S_IDLE) && (state_d != S_DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a      <= '0;
            write  <= '0;
            result <= '0;
            adds   <= '0;
            ovf    <= 1'b0;
        end else begin
            unique case (state_q)
                S_WAIT_A: begin
                    if (signal) begin
                        a <= read;
                        if (read == '0)
                            result <= '0;
                    end else if (wait_expired) begin
                        result <= '0;
                    end
                end
                S_WAIT_B: begin
                    if (signal) begin
                        if (read == '0) begin
                            result <= a;
                        end else begin
                            // A wrapped sum of zero is still sent; ovf records the carry.
                            write <= sum[31:0];
                            ovf   <= ovf | sum[32];
                            if (adds != '1)
                                adds <= adds + CNT_W'(1);
                        end
                    end else if (wait_expired) begin
                        result <= a;
                    end
                end
                S_WAIT_S: begin
                    if (!signal && wait_expired)
                        result <= a;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_accumulator_processor.sv
// Scoreboard bench for accumulator_processor with a behavioural FIFO memory on the bus.
// Define ACCUM_PROC_TIMEOUT_EN to also exercise the wait timeout.
`timescale 1ns/1ps

module tb_accumulator_processor;

    localparam int CNT_W   = 2;
    localparam int TIMEOUT = 16;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_FETCH = 2'b01;
    localparam logic [1:0] OP_SEND  = 2'b10;

    localparam logic [7:0] ST_IDLE   = 8'b0000_0001;
    localparam logic [7:0] ST_WAIT_B = 8'b0001_0000;
    localparam logic [7:0] ST_WAIT_S = 8'b0100_0000;
    localparam logic [7:0] ST_DONE   = 8'b1000_0000;

    typedef struct packed {
        logic [31:0]      result;
        logic [CNT_W-1:0] adds;
        logic             ovf;
    } final_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             signal = 1'b0;
    logic [31:0]      read = 32'hDEAD_BEEF;
    logic [1:0]       op;
    logic [31:0]      write;
    logic             done;
    logic [31:0]      result;
    logic [CNT_W-1:0] adds;
    logic             ovf;
    logic             busy;
    logic [7:0]       state;
`ifdef ACCUM_PROC_TIMEOUT_EN
    logic             timeout_err;
`endif

    accumulator_processor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .signal (signal),
        .read   (read),
        .op     (op),
        .write  (write),
        .done   (done),
        .result (result),
        .adds   (adds),
        .ovf    (ovf),
        .busy   (busy),
        .state  (state)
`ifdef ACCUM_PROC_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic final_t mk_final(input logic [31:0] r, input logic [CNT_W-1:0] n, input logic o);
        final_t f;
        f.result = r;
        f.adds   = n;
        f.ovf    = o;
        return f;
    endfunction

    // Scoreboard queues filled by the stimulus side.
    logic [31:0] exp_send[$];
    final_t      exp_final[$];

    // Behavioural memory: FIFO of operands, answers each command after one idle cycle plus mem_lat.
    logic [31:0] mem_q[$];
    int          mem_lat   = 0;
    bit          mute_send = 1'b0;
    bit          spur_req  = 1'b0;
    int          pend_cnt  = -1;
    logic [1:0]  pend_op   = OP_NOP;

    always @(negedge clk) begin
        signal = 1'b0;
        read   = 32'hDEAD_BEEF;
        if (reset) begin
            mem_q.delete();
            pend_cnt = -1;
        end else if (pend_cnt > 0) begin
            pend_cnt--;
        end else if (pend_cnt == 0) begin
            pend_cnt = -1;
            if (pend_op == OP_FETCH) begin
                signal = 1'b1;
                read   = (mem_q.size() != 0) ? mem_q.pop_front() : 32'd0;
            end else begin
                mem_q.push_back(write);
                signal = !mute_send;
            end
        end else if (op != OP_NOP) begin
            pend_op  = op;
            pend_cnt = mem_lat + 1;
        end
        if (spur_req) begin
            signal   = 1'b1;
            spur_req = 1'b0;
        end
    end

    // Monitor: compares every SEND and every completion against the scoreboard.
    logic [1:0]  prev_op   = OP_NOP;
    logic        prev_done = 1'b0;
    logic [31:0] last_send = '0;
    int          ws_cycles = 0;

    always @(negedge clk) begin
        if (reset) begin
            prev_op   = OP_NOP;
            prev_done = 1'b0;
            ws_cycles = 0;
        end else begin
            if (op != OP_NOP)
                check("op_single_pulse", prev_op, OP_NOP);
            if (op == OP_SEND) begin
                if (exp_send.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_send: got write=0x%0h, expected no SEND", write);
                end else begin
                    check("send_value", write, exp_send.pop_front());
                end
                last_send = write;
            end
            if (state == ST_WAIT_S) begin
                ws_cycles++;
                check("write_hold", write, last_send);
            end
            if (done && !prev_done) begin
                if (exp_final.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1, expected no completion");
                end else begin
                    final_t f;
                    f = exp_final.pop_front();
                    check("final_result", result, f.result);
                    check("final_adds", adds, f.adds);
                    check("final_ovf", ovf, f.ovf);
                end
            end
            prev_op   = op;
            prev_done = done;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    // Starts a run on the preloaded memory and waits (bounded) for done.
    task automatic run_case(input string name, input int lat, input bit poke_start);
        bit finished;
        mem_lat  = lat;
        finished = 1'b0;
        pulse_start();
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(posedge clk);
            #1;
            if (poke_start && cyc == 7) begin
                check({name, "_busy_before_poke"}, busy, 1'b1);
                start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
            finished = done;
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: got done=0, expected done=1 within 3000 cycles", name);
        end
        repeat (2) @(posedge clk);
        check({name, "_sends_drained"}, exp_send.size(), 0);
        check({name, "_final_drained"}, exp_final.size(), 0);
    endtask

    initial begin
        do_reset();
        #1;
        check("rst_state", state, ST_IDLE);
        check("rst_op", op, OP_NOP);
        check("rst_write", write, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_adds", adds, '0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);

        // Spurious signal in IDLE is ignored.
        spur_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("spur_idle_state", state, ST_IDLE);

        // 1,2,3,4 -> sends 3,7,10; start poked mid-run.
        mem_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        exp_send = '{32'd3, 32'd7, 32'd10};
        exp_final.push_back(mk_final(32'd10, 2'd3, 1'b0));
        run_case("sum1234", 0, 1'b1);

        // DONE ignores start and signal.
        spur_req = 1'b1;
        pulse_start();
        repeat (3) @(posedge clk);
        #1;
        check("done_hold_state", state, ST_DONE);
        check("done_hold_done", done, 1'b1);
        check("done_hold_result", result, 32'd10);

        // Empty memory.
        do_reset();
        exp_final.push_back(mk_final(32'd0, 2'd0, 1'b0));
        run_case("empty", 0, 1'b0);

        // Single operand, slow memory.
        do_reset();
        mem_q = '{32'h0000_0005};
        exp_final.push_back(mk_final(32'd5, 2'd0, 1'b0));
        run_case("single", 3, 1'b0);

        // Carry out of bit 31.
        do_reset();
        mem_q = '{32'hFFFF_FFFF, 32'h0000_0002};
        exp_send = '{32'h0000_0001};
        exp_final.push_back(mk_final(32'd1, 2'd1, 1'b1));
        run_case("carry", 1, 1'b0);

        // Sum wraps to exactly zero: sent as 0, then read back as empty.
        do_reset();
        mem_q = '{32'hFFFF_FFFF, 32'h0000_0001};
        exp_send = '{32'h0000_0000};
        exp_final.push_back(mk_final(32'd0, 2'd1, 1'b1));
        run_case("wrap_zero", 0, 1'b0);

        // Four additions saturate the 2-bit counter at 3.
        do_reset();
        mem_q = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
        exp_send = '{32'd2, 32'd2, 32'd3, 32'd5};
        exp_final.push_back(mk_final(32'd5, 2'd3, 1'b0));
        run_case("adds_sat", 0, 1'b0);

        // Reset while waiting for the second operand aborts at once.
        do_reset();
        mem_q = '{32'd5, 32'd6};
        mem_lat = 6;
        pulse_start();
        begin
            bit reached;
            reached = 1'b0;
            for (int cyc = 0; cyc < 100 && !reached; cyc++) begin
                @(posedge clk);
                #1 reached = (state == ST_WAIT_B);
            end
            check("reach_wait_b", reached, 1'b1);
        end
        #2 reset = 1'b1;
        #1;
        check("abort_state", state, ST_IDLE);
        check("abort_op", op, OP_NOP);
        check("abort_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_stays_idle", state, ST_IDLE);
        check("abort_no_done", done, 1'b0);

`ifdef ACCUM_PROC_TIMEOUT_EN
        // Memory never acknowledges the SEND: give up after TIMEOUT cycles in WAIT_S.
        do_reset();
        mute_send = 1'b1;
        mem_q = '{32'd3, 32'd4};
        exp_send = '{32'd7};
        exp_final.push_back(mk_final(32'd3, 2'd1, 1'b0));
        run_case("timeout", 0, 1'b0);
        check("timeout_err", timeout_err, 1'b1);
        check("timeout_wait_cycles", ws_cycles, TIMEOUT);
        mute_send = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
